// File: rtl/yuv_line_addr_gen.sv
// yuv_line_addr_gen
// Write-address generator and flow controller for the YUV line-buffer BRAMs.
// Accepts a pixel stream (data_valid gated by w_ready), produces the BRAM
// write address/strobe, wraps at DEPTH, inserts a reload gap between lines
// and tracks the line index within a frame.
// Optional feature: define YUV_ADDR_PINGPONG_EN to make w_bank toggle on
// every completed line (double buffering); otherwise w_bank is tied to 0.
`timescale 1ns/1ps

module yuv_line_addr_gen #(
  parameter int DEPTH       = 96,
  parameter int AW          = 7,
  parameter int LINES       = 4,
  parameter int LW          = 2,
  parameter int START_DELAY = 2,
  parameter int RELOAD_GAP  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          data_valid,
  output logic          w_ready,
  output logic          w_en,
  output logic [AW-1:0] w_addr,
  output logic [LW-1:0] line_idx,
  output logic          line_done,
  output logic          frame_done,
  output logic          w_bank
);

  // The delay counter is shared by START and GAP, so it is sized for the
  // larger of the two; it only ever counts up to (delay - 1).
  localparam int CMAX = (START_DELAY > RELOAD_GAP) ? START_DELAY : RELOAD_GAP;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0] SD_LAST    = (START_DELAY > 0) ? CW'(START_DELAY - 1) : '0;
  localparam logic [CW-1:0] GAP_LAST   = (RELOAD_GAP > 0)  ? CW'(RELOAD_GAP - 1)  : '0;
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(LINES - 1);
  localparam bit            START_SKIP = (START_DELAY == 0);
  localparam bit            GAP_SKIP   = (RELOAD_GAP == 0);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          line_end;

  // Write strobe is purely combinational so the beat lands in the same cycle.
  assign w_en = data_valid & w_ready;

  // Last beat of the current line is being accepted this cycle.
  assign line_end = w_en && (state == ST_LOAD) && (w_addr == ADDR_LAST);

  // Control FSM: start delay, address/line counting, and the reload gap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= ST_START;
      cnt        <= '0;
      w_ready    <= 1'b0;
      w_addr     <= '0;
      line_idx   <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_START: begin
          if (START_SKIP || (cnt == SD_LAST)) begin
            cnt     <= '0;
            w_ready <= 1'b1;
            state   <= ST_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (w_en) begin
            if (w_addr == ADDR_LAST) begin
              w_addr    <= '0;
              line_done <= 1'b1;
              // Explicit wrap so LINES need not be a power of two.
              if (line_idx == LINE_LAST) begin
                line_idx   <= '0;
                frame_done <= 1'b1;
              end else begin
                line_idx <= line_idx + 1'b1;
              end
              // With no gap, stay in LOAD so lines run back to back.
              if (!GAP_SKIP) begin
                w_ready <= 1'b0;
                cnt     <= '0;
                state   <= ST_GAP;
              end
            end else begin
              w_addr <= w_addr + 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (GAP_SKIP || (cnt == GAP_LAST)) begin
            cnt     <= '0;
            w_ready <= 1'b1;
            state   <= ST_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= ST_START;
          cnt     <= '0;
          w_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef YUV_ADDR_PINGPONG_EN
  // Bank select flips at each line boundary so consecutive lines alternate halves.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_bank <= 1'b0;
    end else if (line_end) begin
      w_bank <= ~w_bank;
    end
  end
`else
  // Single-bank build: no bank register.
  assign w_bank = 1'b0;

  // line_end only drives the bank toggle; keep it referenced in this build.
  logic unused_line_end;
  assign unused_line_end = line_end;
`endif

endmodule

// File: tb/tb_yuv_line_addr_gen.sv
// Directed bench for yuv_line_addr_gen: default-parameter instance plus a
// zero-reload-gap instance for the back-to-back line case.
`timescale 1ns/1ps

module tb_yuv_line_addr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       dv_a, dv_b;

  logic       rdy_a, en_a, ld_a, fd_a, bank_a;
  logic [6:0] addr_a;
  logic [1:0] li_a;
  logic       rdy_b, en_b, ld_b, fd_b, bank_b;
  logic [6:0] addr_b;
  logic [1:0] li_b;

  int vecs = 0;
  int miss = 0;

`ifdef YUV_ADDR_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  always #5 clk = ~clk;

  yuv_line_addr_gen #(
    .DEPTH(96), .AW(7), .LINES(4), .LW(2), .START_DELAY(2), .RELOAD_GAP(4)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .data_valid(dv_a),
    .w_ready(rdy_a), .w_en(en_a), .w_addr(addr_a), .line_idx(li_a),
    .line_done(ld_a), .frame_done(fd_a), .w_bank(bank_a)
  );

  yuv_line_addr_gen #(
    .DEPTH(96), .AW(7), .LINES(4), .LW(2), .START_DELAY(2), .RELOAD_GAP(0)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .data_valid(dv_b),
    .w_ready(rdy_b), .w_en(en_b), .w_addr(addr_b), .line_idx(li_b),
    .line_done(ld_b), .frame_done(fd_b), .w_bank(bank_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_addr;
    int beats;
    int lds;
    int fds;
    int cur_line;
    int n;
    logic exp_bank;

    // ---- Reset, then continuous valid: start delay, line 0, reload gap ----
    rst = 1'b1; flush = 1'b0; dv_a = 1'b1; dv_b = 1'b0;
    adv(); adv(); settle();
    chk("rst_ready", rdy_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_line", li_a, 0);
    chk("rst_ldone", ld_a, 0);
    chk("rst_fdone", fd_a, 0);
    chk("rst_bank", bank_a, 0);
    chk("rst_wen", en_a, 0);

    rst = 1'b0;
    settle();
    chk("start_low0", rdy_a, 0);
    adv(); settle();
    chk("start_low1", rdy_a, 0);
    chk("start_wen1", en_a, 0);
    adv(); settle();
    chk("start_high", rdy_a, 1);

    for (int i = 0; i < 96; i++) begin
      chk("l0_addr", addr_a, i);
      chk("l0_wen", en_a, 1);
      chk("l0_line", li_a, 0);
      chk("l0_bank", bank_a, 0);
      adv(); settle();
    end
    chk("l0_ldone", ld_a, 1);
    chk("l0_fdone", fd_a, 0);
    chk("l0_line_next", li_a, 1);
    chk("l0_wrap_addr", addr_a, 0);
    chk("l0_bank_next", bank_a, PP ? 1 : 0);
    for (int g = 0; g < 4; g++) begin
      chk("gap_low", rdy_a, 0);
      chk("gap_wen", en_a, 0);
      adv(); settle();
      chk("gap_ldone_single", ld_a, 0);
    end
    chk("gap_end_ready", rdy_a, 1);
    chk("l1_start_addr", addr_a, 0);

    // ---- Random valid over lines 1..3 of the frame ----
    exp_addr = 0; beats = 96; lds = 1; fds = 0; cur_line = 1; n = 0;
    while (beats < 384 && n < 4000) begin
      if (ld_a) begin
        lds++;
        cur_line = (cur_line + 1) % 4;
      end
      if (fd_a) fds++;
      dv_a = 1'($urandom_range(0, 1));
      settle();
      if (en_a) begin
        exp_bank = PP ? cur_line[0] : 1'b0;
        chk("rnd_addr", addr_a, exp_addr);
        chk("rnd_line", li_a, cur_line);
        chk("rnd_bank", bank_a, exp_bank);
        beats++;
        exp_addr = (exp_addr == 95) ? 0 : exp_addr + 1;
      end
      adv();
      n++;
    end
    chk("rnd_beats", beats, 384);
    chk("rnd_fdone_early", fds, 0);
    dv_a = 1'b0;
    settle();
    chk("frame_ldone", ld_a, 1);
    chk("frame_fdone", fd_a, 1);
    chk("frame_line_wrap", li_a, 0);
    chk("frame_ldone_count", lds + 1, 4);
    chk("frame_bank", bank_a, 0);
    adv(); settle();
    chk("frame_fdone_pulse", fd_a, 0);

    // ---- Flush at address 50 of line 2 ----
    dv_a = 1'b1;
    n = 0;
    settle();
    while (!(li_a == 2'd2 && addr_a == 7'd50 && rdy_a) && n < 1500) begin
      adv(); settle();
      n++;
    end
    chk("flush_reach", {li_a, addr_a}, {2'd2, 7'd50});
    flush = 1'b1;
    settle();
    chk("flush_wen", en_a, 1);
    adv();
    flush = 1'b0;
    settle();
    chk("flush_addr", addr_a, 0);
    chk("flush_line", li_a, 0);
    chk("flush_ready", rdy_a, 0);
    chk("flush_ldone", ld_a, 0);
    chk("flush_bank", bank_a, 0);
    adv(); settle();
    chk("flush_low1", rdy_a, 0);
    adv(); settle();
    chk("flush_ready_back", rdy_a, 1);
    chk("flush_addr_hold", addr_a, 0);

    // ---- Reset in the middle of the reload gap ----
    n = 0;
    while (!ld_a && n < 300) begin
      adv(); settle();
      n++;
    end
    chk("gap_reach", ld_a, 1);
    adv(); settle();
    chk("midgap_low", rdy_a, 0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    settle();
    chk("rst2_ready", rdy_a, 0);
    chk("rst2_addr", addr_a, 0);
    chk("rst2_line", li_a, 0);
    chk("rst2_ldone", ld_a, 0);
    chk("rst2_fdone", fd_a, 0);
    chk("rst2_bank", bank_a, 0);
    adv(); settle();
    chk("rst2_low1", rdy_a, 0);
    adv(); settle();
    chk("rst2_high", rdy_a, 1);
    chk("rst2_addr0", addr_a, 0);
    dv_a = 1'b0;

    // ---- Zero reload gap: continuous valid runs lines back to back ----
    chk("nogap_ready_init", rdy_b, 1);
    dv_b = 1'b1;
    exp_addr = 0;
    settle();
    for (int i = 0; i < 200; i++) begin
      chk("nogap_ready", rdy_b, 1);
      chk("nogap_addr", addr_b, exp_addr);
      if (i == 96) chk("nogap_ldone", ld_b, 1);
      exp_addr = (exp_addr == 95) ? 0 : exp_addr + 1;
      adv(); settle();
    end
    chk("nogap_line", li_b, 2);
    dv_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/yuv_line_addr_gen.md
# yuv_line_addr_gen

Parametrised write-address generator and flow controller for the YUV line-buffer BRAMs. It accepts a pixel stream qualified by `data_valid`, gated by `w_ready`, and produces the BRAM write address and enable. It wraps at a programmable line depth, inserts a programmable reload gap between lines, and counts lines per frame. It sits between the pixel source and the line BRAM, and generalises the fixed 96-entry address counter to arbitrary depth, line count and gap.

## Interface
- `DEPTH`, 96: entries per line; the address wraps at `DEPTH-1`.
- `AW`, 7: address width; must satisfy 2^AW ≥ DEPTH.
- `LINES`, 4: lines per frame.
- `LW`, 2: line-index width; must satisfy 2^LW ≥ LINES.
- `START_DELAY`, 2: cycles `w_ready` stays low after reset or flush.
- `RELOAD_GAP`, 4: cycles `w_ready` stays low after each line completes; 0 means no gap.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous restart of the line and frame position.
- `data_valid`  in  1  source has a pixel this cycle.
- `w_ready`  out  1  registered; block will accept a pixel.
- `w_en`  out  1  combinational, `data_valid & w_ready`; the BRAM write strobe.
- `w_addr`  out  AW  BRAM write address for the current beat.
- `line_idx`  out  LW  index of the line being written.
- `line_done`  out  1  one-cycle pulse after the last beat of a line.
- `frame_done`  out  1  one-cycle pulse after the last beat of line `LINES-1`.
- `w_bank`  out  1  ping-pong bank select; see Configuration.

## Operation
- A beat is accepted when `w_en` = 1. `data_valid` is ignored while `w_ready` = 0, and `w_addr` holds.
- FSM states are START, LOAD and GAP. Reset and flush both enter START with the cycle counter at 0.
- START: count `START_DELAY` cycles, then set `w_ready` to 1 and move to LOAD. With `START_DELAY` = 0, `w_ready` is 1 on the first cycle after `rst` or `flush` deasserts.
- LOAD: on each accept, `w_addr` increments by 1.
- LOAD, accept at `w_addr == DEPTH-1`:
  - `w_addr` wraps to 0 and `line_done` pulses.
  - `line_idx` increments. At `LINES-1` it wraps to 0 and `frame_done` pulses together with `line_done`.
  - If `RELOAD_GAP` > 0: `w_ready` goes to 0 and the FSM moves to GAP.
  - If `RELOAD_GAP` = 0: `w_ready` stays 1 and the FSM stays in LOAD, so back-to-back lines run with no bubble.
- GAP: count `RELOAD_GAP` cycles with `w_ready` = 0, then set `w_ready` to 1 and return to LOAD.
- Priority is `rst` > `flush` > accept. A `flush` in the same cycle as an accept discards the beat's address advance; `w_en` is still asserted combinationally for that beat.
- `flush` sets `w_addr`, `line_idx` and `w_bank` to 0, sets `w_ready` to 0, and moves to START. It does not generate `line_done` or `frame_done`.
- Addresses at or above `DEPTH` are never produced.

## Timing
- Reset values: `w_ready` 0, `w_addr` 0, `line_idx` 0, `line_done` 0, `frame_done` 0, `w_bank` 0, FSM START.
- `w_en` has zero latency from `data_valid`. `w_addr` is valid in the same cycle as `w_en`.
- `w_ready` falls in the cycle after the last beat is accepted, so exactly `DEPTH` beats are accepted per line.
- `line_done` and `frame_done` are registered and high for the one cycle following the last accept.
- In GAP, `w_ready` is low for exactly `RELOAD_GAP` cycles. In START, it is low for exactly `START_DELAY` cycles.
- All counters are sized to their parameters and saturate-free. `line_idx` wrap is explicit and does not rely on power-of-two overflow.

## Configuration
- `YUV_ADDR_PINGPONG_EN` defined: `w_bank` toggles on every `line_done`, selecting alternate BRAM halves for double buffering.
- `YUV_ADDR_PINGPONG_EN` undefined: `w_bank` is tied to 0 and its register is removed.
- All other behaviour is identical in both builds.

## Test plan
Defaults throughout: DEPTH=96, LINES=4, START_DELAY=2, RELOAD_GAP=4.
- Reset, then `data_valid` held at 1 → `w_ready` low for 2 cycles, then 96 writes at `w_addr` 0..95. `line_done` pulses once, then `w_ready` is low for 4 cycles and line 1 starts at addr 0.
- `data_valid` toggling randomly for 4 lines → exactly 384 `w_en` pulses, each line's addresses contiguous 0..95, and `frame_done` once, coincident with the 4th `line_done`. `line_idx` returns to 0.
- `RELOAD_GAP`=0, continuous valid → `w_addr` goes 95 then 0 on consecutive cycles and `w_ready` never drops after START.
- `flush` asserted at `w_addr`=50 on line 2 → next cycle `w_addr`=0, `line_idx`=0, `w_ready`=0, no `line_done`. Then after 2 cycles `w_ready`=1.
- `rst` asserted mid-GAP → all outputs at reset values the next cycle. Restart timing is identical to the first scenario.
- With `YUV_ADDR_PINGPONG_EN` defined → `w_bank` reads 0,1,0,1 across 4 lines. Without it, `w_bank` stays 0.
